clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Run-time controller for a programmable 50%-duty clock divider. Sequences start, stop and divisor reconfiguration so that the divided output `q` never glitches or emits a runt phase. Changes take effect only at a full-period boundary. Sits between a configuration master (valid/ready port) and the logic clocked or enabled by `q`/`tick`.

Parameters:
WIDTH, 8, bit width of the divisor (half-period length in `clk` cycles).
DEFAULT_DIV, 4, divisor loaded at reset; must be in 1..2^WIDTH-1.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
en  input  1  run request; level-sensitive.
cfg_valid  input  1  new divisor offered.
cfg_div  input  WIDTH  offered divisor (half-period in `clk` cycles).
cfg_ready  output  1  controller can accept a divisor.
cfg_err  output  1  one-cycle pulse: accepted `cfg_div` was 0 and was discarded.
q  output  1  divided clock; high DIV cycles, low DIV cycles.
tick  output  1  one-cycle pulse in the cycle `q` rises.
busy  output  1  high in RUN or STOPPING.

Behaviour:
- Reset (`rst` == 0, asynchronous):
  - `q`=0, `tick`=0, `busy`=0, `cfg_err`=0, `cfg_ready`=1.
  - State IDLE, active div=DEFAULT_DIV, pending cleared, cnt=0.
  - Applies immediately, mid-period included.
- All outputs are registered.
- Counter `cnt` runs 0..div-1. At cnt==div-1, `q` toggles and `cnt` returns to 0.
- Period boundary: the cycle with `q`==0 and cnt==div-1.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: `q`=0. If `en`=1, next edge moves to RUN with `q`<=1, `tick`<=1, cnt<=0. Latency from `en` to `q` high is 1 cycle.
  - RUN: if `en`=0, go to STOPPING; the current period continues unchanged.
  - RUN at a period boundary with `en`=1: `q`<=1, `tick`<=1; a pending divisor is applied here.
  - STOPPING at a period boundary: go to IDLE, `q` stays 0, `busy` drops the same edge, pending applied.
  - STOPPING with `en` back to 1 before the boundary: return to RUN with no phase disturbance.
- Config handshake: a transfer occurs on `cfg_valid` && `cfg_ready`.
  - `cfg_div`==0: discarded, `cfg_err`=1 next cycle, `cfg_ready` stays 1.
  - Nonzero in IDLE: active div updated next cycle, pending not set.
  - Nonzero in RUN/STOPPING: stored as pending and `cfg_ready`<=0 until applied at the next period boundary.
  - `cfg_ready` returns to 1 the cycle after apply.
- Simultaneous events:
  - Config transfer in the same cycle as a boundary: not applied at that boundary; waits for the next one.
  - `en` falling on a boundary cycle: period ends, go to IDLE directly.
- div=1: `q` toggles every cycle; `tick` every 2 cycles.

Optional Feature:
CLK_DIV_CTRL_CNT_EN
- Defined: adds output `period_cnt` [15:0].
  - Increments at each completed period.
  - Saturates at 16'hFFFF.
  - Cleared by reset and on the IDLE->RUN transition.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header `clk_div_ctrl_pkg` holds:
  - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_STOPPING=2'd2;
  - DIV_MIN=1;
  - PCNT_W=16.
- Sub-module `clk_div_core` holds the counter, `q` toggle and boundary detect. Inputs: div, run, load_strobe. Outputs: q, boundary.
- `clk_div_ctrl` holds the FSM, the handshake and the pending register.

Test Plan:
1. Start-up: reset release, DEFAULT_DIV=4, `en`=1 at cycle 2 -> `q` high cycles 3-6, low 7-10, repeating; `tick` at cycles 3, 11, 19.
2. Reconfigure while running: `cfg_div`=2 accepted mid-high phase -> current period stays 4/4; next periods 2/2; `cfg_ready`=0 until the boundary and 1 the cycle after.
3. Back-to-back configs: second `cfg_valid` (div=6) while pending -> held off (`cfg_ready`=0); accepted after the first applies; takes effect one period later.
4. Bad divisor: `cfg_div`=0 -> `cfg_err` one-cycle pulse; divisor unchanged; `cfg_ready`=1 throughout.
5. Graceful stop and resume:
   - `en`=0 during a high phase -> period completes, `q`=0, `busy` falls at the boundary.
   - `en`=0 then 1 within the low phase -> no extra edge, periods continuous.
6. Reset mid-run: `rst`=0 asynchronously while `q`=1 -> `q`=0 and `busy`=0 without waiting for a clock edge; div back to 4; the pending config is lost.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Purpose: shared types and constants for the programmable clock-divider controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_e;

    // Smallest legal divisor; anything below is rejected at the config port.
    localparam int DIV_MIN = 1;

    // Width of the optional completed-period counter.
    localparam int PCNT_W = 16;

endpackage

// File: rtl/clk_div_core.sv
// Purpose: half-period counter, q toggle and period-boundary detect for the divider.
// Latency: q is registered; load_strobe/run act on the next clk edge.
// Backpressure: none; follows run/load_strobe every cycle.
//
// Ports:
//   clk, rst       clock and async active-low reset
//   div            active half-period length in clk cycles (>= 1)
//   run            1 = count and toggle, 0 = hold q low with counter cleared
//   load_strobe    start a fresh period: q high, counter at 0
//   q              divided clock (registered)
//   boundary       combinational: last cycle of the low phase
module clk_div_core
    import clk_div_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] div,
    input  logic             run,
    input  logic             load_strobe,
    output logic             q,
    output logic             boundary
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             last_cnt;

    always_comb begin
        last_cnt = (cnt_q == (div - WIDTH'(1)));
        boundary = !q_q && last_cnt;
        cnt_d    = cnt_q;
        q_d      = q_q;
        if (!run) begin
            cnt_d = '0;
            q_d   = 1'b0;
        end else if (load_strobe) begin
            cnt_d = '0;
            q_d   = 1'b1;
        end else if (last_cnt) begin
            cnt_d = '0;
            q_d   = !q_q;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Purpose: glitch-free start/stop/reconfigure sequencer for a 50%-duty clock divider.
// Latency: en -> q high in 1 cycle; divisor changes land on the next full-period boundary.
// Backpressure: cfg_ready drops while a divisor is pending and rises the cycle after it applies.
//
// Ports:
//   clk, rst            clock and async active-low reset
//   en                  level run request
//   cfg_valid/cfg_div   divisor offer; transfer on cfg_valid && cfg_ready
//   cfg_ready           controller can take a divisor
//   cfg_err             one-cycle pulse when a zero divisor was taken and dropped
//   q, tick             divided clock and its rising-edge pulse
//   busy                running or finishing the last period
//   period_cnt          saturating completed-period count (only with CLK_DIV_CTRL_CNT_EN)
// Build option: define CLK_DIV_CTRL_CNT_EN to add period_cnt.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    input  logic [WIDTH-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic              q,
    output logic              tick,
`ifdef CLK_DIV_CTRL_CNT_EN
    output logic [PCNT_W-1:0] period_cnt,
`endif
    output logic              busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             busy_q, busy_d;

    logic             active;
    logic             bnd;
    logic             xfer;
    logic             load;
    logic             core_boundary;

    clk_div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .div         (div_q),
        .run         (busy_d),
        .load_strobe (load),
        .q           (q),
        .boundary    (core_boundary)
    );

    always_comb begin
        active      = (state_q != S_IDLE);
        // The core flags a boundary even while parked; only trust it when running.
        bnd         = active && core_boundary;
        xfer        = cfg_valid && cfg_ready_q;
        state_d     = state_q;
        div_d       = div_q;
        pend_d      = pend_q;
        pend_div_d  = pend_div_q;
        tick_d      = 1'b0;
        cfg_err_d   = 1'b0;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A divisor accepted on the final boundary of a stop has no
                // further period to wait for, so it is applied straight away.
                if (pend_q) begin
                    div_d  = pend_div_q;
                    pend_d = 1'b0;
                end
                if (en) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            S_RUN, S_STOPPING: begin
                if (bnd) begin
                    if (pend_q) begin
                        div_d  = pend_div_q;
                        pend_d = 1'b0;
                    end
                    if (en) begin
                        state_d = S_RUN;
                        tick_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    // Mid-period: the phase keeps running either way, en only
                    // decides whether this period is the last one.
                    state_d = en ? S_RUN : S_STOPPING;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // pend_q blocks cfg_ready, so this never collides with an apply above.
        if (xfer) begin
            if (cfg_div < WIDTH'(DIV_MIN)) begin
                cfg_err_d = 1'b1;
            end else if (!active) begin
                div_d = cfg_div;
            end else begin
                pend_d     = 1'b1;
                pend_div_d = cfg_div;
            end
        end

        cfg_ready_d = !pend_d;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            div_q       <= WIDTH'(DEFAULT_DIV);
            pend_q      <= 1'b0;
            pend_div_q  <= '0;
            tick_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            pend_q      <= pend_d;
            pend_div_q  <= pend_div_d;
            tick_q      <= tick_d;
            cfg_err_q   <= cfg_err_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign tick      = tick_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;

`ifdef CLK_DIV_CTRL_CNT_EN
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

    always_comb begin
        pcnt_d = pcnt_q;
        if (load) begin
            pcnt_d = '0;
        end else if (bnd && (pcnt_q != {PCNT_W{1'b1}})) begin
            pcnt_d = pcnt_q + PCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign period_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Purpose: self-checking bench for clk_div_ctrl with a phase-level reference model.
// Latency: expectations are pushed at the negedge and checked 1 time unit after the next posedge.
// Backpressure: the model honours cfg_ready when deciding whether an offer transfers.
module tb_clk_div_ctrl;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [WIDTH-1:0] cfg_div = '0;
    logic             cfg_ready, cfg_err, q, tick, busy;
`ifdef CLK_DIV_CTRL_CNT_EN
    logic [15:0]      period_cnt;
`endif

    clk_div_ctrl #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .q          (q),
        .tick       (tick),
`ifdef CLK_DIV_CTRL_CNT_EN
        .period_cnt (period_cnt),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        q;
        logic        tick;
        logic        busy;
        logic        cfg_ready;
        logic        cfg_err;
        logic [15:0] pcnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the divider is described as "level q held for m_left
    // more cycles", plus a running flag and an optional pending divisor.
    bit m_active, m_q, m_pend, m_ready, m_tick, m_err;
    int m_left, m_div, m_pdiv, m_pcnt;

    task automatic model_reset();
        m_active = 0; m_q = 0; m_left = 0; m_div = DEFAULT_DIV;
        m_pend = 0; m_pdiv = 0; m_ready = 1; m_tick = 0; m_err = 0; m_pcnt = 0;
    endtask

    task automatic model_step(input bit i_en, input bit i_v, input int i_d);
        bit was_active = m_active;
        bit period_end = m_active && !m_q && (m_left == 1);
        bit xfer       = i_v && m_ready;
        m_tick = 0;
        m_err  = 0;
        if (!was_active) begin
            if (m_pend) begin
                m_div  = m_pdiv;
                m_pend = 0;
            end
            if (xfer && i_d != 0) m_div = i_d;
            if (i_en) begin
                m_active = 1; m_q = 1; m_left = m_div; m_tick = 1; m_pcnt = 0;
            end
        end else if (period_end) begin
            if (m_pcnt < 65535) m_pcnt++;
            if (m_pend) begin
                m_div  = m_pdiv;
                m_pend = 0;
            end
            if (i_en) begin
                m_q = 1; m_left = m_div; m_tick = 1;
            end else begin
                m_active = 0; m_q = 0;
            end
        end else if (m_left == 1) begin
            m_q    = !m_q;
            m_left = m_div;
        end else begin
            m_left--;
        end
        if (xfer) begin
            if (i_d == 0) m_err = 1;
            else if (was_active) begin
                m_pend = 1;
                m_pdiv = i_d;
            end
        end
        m_ready = !m_pend;
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.q         = m_q;
        o.tick      = m_tick;
        o.busy      = m_active;
        o.cfg_ready = m_ready;
        o.cfg_err   = m_err;
`ifdef CLK_DIV_CTRL_CNT_EN
        o.pcnt      = 16'(m_pcnt);
`else
        o.pcnt      = 16'd0;
`endif
        return o;
    endfunction

    task automatic drive_step(input bit a_en, input bit a_v, input int a_d);
        en        = a_en;
        cfg_valid = a_v;
        cfg_div   = WIDTH'(a_d);
        model_step(a_en, a_v, a_d);
        exp_q.push_back(model_out());
    endtask

    task automatic cyc(input bit a_en, input bit a_v, input int a_d);
        @(negedge clk);
        drive_step(a_en, a_v, a_d);
    endtask

    // Reset lands mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input int ncyc);
        @(negedge clk);
        #2;
        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        #1;
        n_cmp++;
        if (q !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || tick !== 1'b0 || cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset t=%0t got q=%b busy=%b rdy=%b tick=%b err=%b expected q=0 busy=0 rdy=1 tick=0 err=0",
                     $time, q, busy, cfg_ready, tick, cfg_err);
        end
        model_reset();
        for (int i = 0; i < ncyc; i++) begin
            exp_q.push_back(model_out());
            @(negedge clk);
        end
        rst = 1'b1;
        drive_step(1'b0, 1'b0, 0);
    endtask

    // Keeps driving until q reaches the wanted level while busy; bounded.
    task automatic wait_q(input logic lvl, input bit a_en);
        bit hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (q === lvl && busy === 1'b1) hit = 1;
            else cyc(a_en, 1'b0, 0);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL wait_q t=%0t got q=%b busy=%b expected q=%b busy=1 within 60 cycles", $time, q, busy, lvl);
        end
    endtask

    // Monitor: every clock edge presents one output sample.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.q         = q;
                a.tick      = tick;
                a.busy      = busy;
                a.cfg_ready = cfg_ready;
                a.cfg_err   = cfg_err;
`ifdef CLK_DIV_CTRL_CNT_EN
                a.pcnt      = period_cnt;
`else
                a.pcnt      = 16'd0;
`endif
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle_check t=%0t got q=%b tick=%b busy=%b rdy=%b err=%b pcnt=%0d expected q=%b tick=%b busy=%b rdy=%b err=%b pcnt=%0d",
                             $time, a.q, a.tick, a.busy, a.cfg_ready, a.cfg_err, a.pcnt,
                             e.q, e.tick, e.busy, e.cfg_ready, e.cfg_err, e.pcnt);
                end
            end
        end
    end

    initial begin
        bit ren;
        bit rv;
        int rd;
        model_reset();
        do_reset(2);

        // Start-up with the default divisor.
        cyc(1'b0, 1'b0, 0);
        repeat (24) cyc(1'b1, 1'b0, 0);

        // Reconfigure mid-high phase, then a second offer held while pending.
        wait_q(1'b1, 1'b1);
        cyc(1'b1, 1'b1, 2);
        repeat (3) cyc(1'b1, 1'b0, 0);
        repeat (12) cyc(1'b1, 1'b1, 6);
        repeat (30) cyc(1'b1, 1'b0, 0);

        // Zero divisor is rejected.
        cyc(1'b1, 1'b1, 0);
        repeat (16) cyc(1'b1, 1'b0, 0);

        // Graceful stop during a high phase, then restart.
        wait_q(1'b1, 1'b1);
        repeat (16) cyc(1'b0, 1'b0, 0);
        repeat (8) cyc(1'b1, 1'b0, 0);

        // Stop request withdrawn inside the low phase.
        wait_q(1'b0, 1'b1);
        cyc(1'b0, 1'b0, 0);
        repeat (20) cyc(1'b1, 1'b0, 0);

        // Divisor 1 and reconfigure while idle.
        cyc(1'b1, 1'b1, 1);
        repeat (14) cyc(1'b1, 1'b0, 0);
        repeat (4) cyc(1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 3);
        repeat (14) cyc(1'b1, 1'b0, 0);

        // Reset mid-run with a divisor pending.
        wait_q(1'b1, 1'b1);
        cyc(1'b1, 1'b1, 7);
        cyc(1'b1, 1'b0, 0);
        do_reset(3);
        repeat (20) cyc(1'b1, 1'b0, 0);

        // Randomized traffic.
        ren = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(39) == 0) ren = !ren;
            rv = ($urandom_range(7) == 0);
            case ($urandom_range(5))
                0:       rd = 0;
                1:       rd = 1;
                2:       rd = 2;
                default: rd = int'($urandom_range(10, 1));
            endcase
            if (k == 1500) do_reset(2);
            else cyc(ren, rv, rd);
        end

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
